// File: rtl/width_multiplier_pkg.sv
// width_multiplier_pkg: shared width constants for the 64-bit to 256-bit stream packer.
package width_multiplier_pkg;
   localparam int S_DATA_W = 64;
   localparam int M_DATA_W = 256;
   localparam int LANES    = 4;
   localparam int PTR_W    = 2;
endpackage

// File: rtl/width_multiplier.sv
// width_multiplier: packs up to four consecutive input beats of one packet into one wide output word.
module width_multiplier
   import width_multiplier_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH = S_DATA_W,
   parameter int C_M_AXIS_DATA_WIDTH = M_DATA_W,
   parameter int C_TUSER_WIDTH       = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic [C_TUSER_WIDTH-1:0]         s_axis_tuser,
   input  logic                             s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [C_TUSER_WIDTH-1:0]         m_axis_tuser,
   output logic                             m_axis_tlast
);
   localparam int SW = C_S_AXIS_DATA_WIDTH;
   localparam int SK = SW / 8;
   localparam int MW = C_M_AXIS_DATA_WIDTH;
   localparam int MK = MW / 8;
   localparam int LN = LANES;

   logic [PTR_W-1:0]         ptr;
   logic [MW-1:0]            acc_data, nxt_data;
   logic [MK-1:0]            acc_keep, nxt_keep;
   logic [C_TUSER_WIDTH-1:0] acc_user;
   logic                     accept, done;

   assign s_axis_tready = !m_axis_tvalid | m_axis_tready;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign done          = accept & ((ptr == PTR_W'(LN - 1)) | s_axis_tlast);

   // Accumulator is cleared on every completion, so unfilled lanes stay zero.
   always_comb begin
      nxt_data = acc_data;
      nxt_keep = acc_keep;
      for (int i = 0; i < LN; i++)
         if (ptr == PTR_W'(i)) begin
            nxt_data[i*SW +: SW] = s_axis_tdata;
            nxt_keep[i*SK +: SK] = s_axis_tkeep;
         end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr           <= '0;
         acc_data      <= '0;
         acc_keep      <= '0;
         acc_user      <= '0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else if (done) begin
         m_axis_tdata  <= nxt_data;
         m_axis_tkeep  <= nxt_keep;
         m_axis_tuser  <= acc_user | s_axis_tuser;
         m_axis_tlast  <= s_axis_tlast;
         m_axis_tvalid <= 1'b1;
         ptr           <= '0;
         acc_data      <= '0;
         acc_keep      <= '0;
         acc_user      <= '0;
      end else begin
         if (accept) begin
            acc_data <= nxt_data;
            acc_keep <= nxt_keep;
            acc_user <= acc_user | s_axis_tuser;
            ptr      <= ptr + 1'b1;
         end
         if (m_axis_tready)
            m_axis_tvalid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_width_multiplier.sv
// tb_width_multiplier: directed and randomized checks of the stream packer against a word-level model.
module tb_width_multiplier;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [63:0]  s_tdata = '0;
   logic [7:0]   s_tkeep = '0;
   logic         s_tvalid = 1'b0;
   logic         s_tready;
   logic [0:0]   s_tuser = '0;
   logic         s_tlast = 1'b0;
   logic [255:0] m_tdata;
   logic [31:0]  m_tkeep;
   logic         m_tvalid;
   logic         m_tready = 1'b1;
   logic [0:0]   m_tuser;
   logic         m_tlast;

   width_multiplier dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [255:0] d;
      logic [31:0]  k;
      logic         u;
      logic         l;
   } word_t;

   word_t        exp_q[$];
   logic [255:0] pd = '0;
   logic [31:0]  pk = '0;
   logic         pu = 1'b0;
   int           pc = 0;
   int           checks = 0, fails = 0, words = 0, cyc = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: beats collect into a pending word; a word is expected once 4 beats or a tlast arrive.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         chk("rst_m_tvalid", m_tvalid, 0);
         chk("rst_m_tdata", m_tdata, 0);
         chk("rst_m_tkeep", m_tkeep, 0);
         chk("rst_m_tuser", m_tuser, 0);
         chk("rst_m_tlast", m_tlast, 0);
         chk("rst_s_tready", s_tready, 1);
         exp_q.delete();
         pd = '0; pk = '0; pu = 1'b0; pc = 0;
      end else begin
         chk("s_tready", s_tready, !m_tvalid || m_tready);
         chk("m_tvalid", m_tvalid, exp_q.size() > 0);
         if (m_tvalid && exp_q.size() > 0) begin
            chk("m_tdata", m_tdata, exp_q[0].d);
            chk("m_tkeep", m_tkeep, exp_q[0].k);
            chk("m_tuser", m_tuser, exp_q[0].u);
            chk("m_tlast", m_tlast, exp_q[0].l);
            if (m_tready) begin
               void'(exp_q.pop_front());
               words++;
            end
         end
         if (s_tvalid && s_tready) begin
            pd[64*pc +: 64] = s_tdata;
            pk[8*pc +: 8]   = s_tkeep;
            pu              = pu | s_tuser[0];
            pc++;
            if (pc == 4 || s_tlast) begin
               exp_q.push_back('{d: pd, k: pk, u: pu, l: s_tlast});
               pd = '0; pk = '0; pu = 1'b0; pc = 0;
            end
         end
      end
   end

   task automatic send(input logic [63:0] d, input logic [7:0] k, input logic u, input logic l);
      int n = 0;
      s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) chk("send_timeout", 1, 0);
      @(posedge clk);
      #1 s_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int c0, w0;
      logic [255:0] held;
      idle(3);
      reset = 1'b1;
      idle(1);

      // Four full beats, tlast on beat 4
      for (int i = 1; i <= 4; i++) send(64'(i), 8'hFF, 1'b0, i == 4);
      chk("w1_tvalid_lat", m_tvalid, 1);
      chk("w1_tdata", m_tdata, 256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
      chk("w1_tkeep", m_tkeep, 32'hFFFFFFFF);
      chk("w1_tlast", m_tlast, 1);
      idle(2);

      // Three beats, partial last beat
      send(64'hA, 8'hFF, 1'b0, 1'b0);
      send(64'hB, 8'hFF, 1'b0, 1'b0);
      send(64'hC, 8'h0F, 1'b0, 1'b1);
      chk("w3_tkeep", m_tkeep, 32'h000FFFFF);
      chk("w3_upper_zero", m_tdata[255:192], 0);
      chk("w3_tlast", m_tlast, 1);
      idle(2);

      // tuser ORed across the word, then cleared for the next
      for (int i = 0; i < 4; i++) send(64'(100 + i), 8'hFF, i == 1, 1'b0);
      chk("user_or", m_tuser, 1);
      chk("user_nolast", m_tlast, 0);
      for (int i = 0; i < 4; i++) send(64'(200 + i), 8'hFF, 1'b0, i == 3);
      chk("user_clear", m_tuser, 0);
      idle(2);

      // Output stall: word 1 must hold while downstream is not ready
      for (int i = 0; i < 4; i++) send(64'(16 + i), 8'hFF, 1'b0, 1'b0);
      m_tready = 1'b0;
      held = m_tdata;
      chk("stall_w1", held, 256'h0000000000000013_0000000000000012_0000000000000011_0000000000000010);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_s_tready", s_tready, 0);
         chk("stall_hold", m_tdata, held);
      end
      @(posedge clk);
      #1 m_tready = 1'b1;
      for (int i = 0; i < 4; i++) send(64'(20 + i), 8'hFF, 1'b0, i == 3);
      chk("stall_w2", m_tdata, 256'h0000000000000017_0000000000000016_0000000000000015_0000000000000014);
      idle(2);

      // Continuous stream: one beat per cycle, 16 words
      c0 = cyc; w0 = words;
      for (int i = 0; i < 64; i++) send({$urandom, $urandom}, 8'hFF, 1'b0, (i % 4) == 3);
      chk("stream_cycles", cyc - c0, 64);
      idle(3);
      chk("stream_words", words - w0, 16);

      // Reset mid-packet discards the partial word
      send(64'h1111, 8'hFF, 1'b0, 1'b0);
      send(64'h2222, 8'hFF, 1'b0, 1'b0);
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(1);
      w0 = words;
      send(64'hDEADBEEFAFFEDEAD, 8'hFF, 1'b0, 1'b1);
      chk("rst_pkt_tdata", m_tdata, 256'h00000000000000000000000000000000000000000000000000000000DEADBEEFAFFEDEAD);
      chk("rst_pkt_tkeep", m_tkeep, 32'h000000FF);
      idle(3);
      chk("rst_pkt_words", words - w0, 1);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 3000; i++) begin
         s_tvalid = ($urandom_range(9) < 7);
         s_tdata  = {$urandom, $urandom};
         s_tkeep  = 8'($urandom);
         s_tuser  = ($urandom_range(7) == 0);
         s_tlast  = ($urandom_range(4) == 0);
         m_tready = ($urandom_range(9) < 6);
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      idle(4);
      chk("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
